// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - in-order decoded-instruction FIFO feeding the SALU issue slot
//
// Buffers up to DEPTH decoded instructions in a circular buffer and issues one
// per cycle through a registered issue slot.
//
// Ports:
//   clk, rst (async active-low)    clock / reset
//   rdy                            global enable; all state holds when 0
//   flush                          drop every queued and issuing instruction
//   issue_stall                    downstream cannot take a new issue
//   in_valid / in_ready            decoder handshake (in_ready = count != DEPTH)
//   in_is_vec..in_rs2              decoded instruction payload
//   issue_rdy                      issue slot holds a valid instruction
//   is_vec..rs2                    registered issue-slot payload
//   count                          current occupancy
//
// Optional feature: define IQ_BYPASS_EN to let a push into an empty, unstalled
// queue load the issue slot directly (1-edge latency instead of 2).

module issue_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              issue_stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_vec,
    input  logic              in_is_imm,
    input  logic              in_is_pc,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_imm,
    input  logic [5:0]        in_name,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    output logic              issue_rdy,
    output logic              is_vec,
    output logic              is_imm,
    output logic              is_pc,
    output logic [31:0]       pc,
    output logic [31:0]       imm,
    output logic [5:0]        name,
    output logic [4:0]        rd,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [ADDR_W:0]   count
);

    localparam int ENT_W = 3 + 32 + 32 + 6 + 5 + 5 + 5;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  in_ent;
    logic [ENT_W-1:0]  slot;
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;

    logic empty;
    logic push;
    logic pop;
    logic bypass;
    logic wr;

    assign in_ent = {in_is_vec, in_is_imm, in_is_pc, in_pc, in_imm,
                     in_name, in_rd, in_rs1, in_rs2};

    assign {is_vec, is_imm, is_pc, pc, imm, name, rd, rs1, rs2} = slot;

    // Depends on registered count only: no input-to-output combinational path.
    assign in_ready = (count != (ADDR_W + 1)'(DEPTH));
    assign empty    = (count == '0);

    assign push = rdy & ~flush & in_valid & in_ready;
    assign pop  = rdy & ~flush & ~issue_stall & ~empty;

`ifdef IQ_BYPASS_EN
    // Only possible when empty, so it never competes with a pop.
    assign bypass = push & empty & ~issue_stall;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction never touches storage.
    assign wr = push & ~bypass;

    // Storage needs no reset: only entries between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[tail] <= in_ent;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            issue_rdy <= 1'b0;
            slot      <= '0;
        end else if (rdy) begin
            if (flush) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                issue_rdy <= 1'b0;
            end else begin
                if (wr) begin
                    tail <= tail + ADDR_W'(1);
                end
                if (pop) begin
                    head <= head + ADDR_W'(1);
                end

                case ({wr, pop})
                    2'b10:   count <= count + (ADDR_W + 1)'(1);
                    2'b01:   count <= count - (ADDR_W + 1)'(1);
                    default: count <= count;
                endcase

                // Payload holds on idle cycles; only issue_rdy drops.
                if (pop) begin
                    slot      <= mem[head];
                    issue_rdy <= 1'b1;
                end else if (bypass) begin
                    slot      <= in_ent;
                    issue_rdy <= 1'b1;
                end else begin
                    issue_rdy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - self-checking bench for issue_queue with a queue-based reference model

module tb_issue_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [5:0] ADD = 6'd1;
    localparam logic [5:0] SUB = 6'd2;
    localparam logic [5:0] LW  = 6'd3;

    typedef struct packed {
        logic        is_vec;
        logic        is_imm;
        logic        is_pc;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [5:0]  name;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    logic flush = 1'b0;
    logic issue_stall = 1'b0;
    logic in_valid = 1'b0;
    ent_t in_e = '0;

    logic              in_ready;
    logic              issue_rdy;
    logic              is_vec, is_imm, is_pc;
    logic [31:0]       pc, imm;
    logic [5:0]        name;
    logic [4:0]        rd, rs1, rs2;
    logic [ADDR_W:0]   count;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    issue_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst_n), .rdy(rdy), .flush(flush), .issue_stall(issue_stall),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_vec(in_e.is_vec), .in_is_imm(in_e.is_imm), .in_is_pc(in_e.is_pc),
        .in_pc(in_e.pc), .in_imm(in_e.imm), .in_name(in_e.name),
        .in_rd(in_e.rd), .in_rs1(in_e.rs1), .in_rs2(in_e.rs2),
        .issue_rdy(issue_rdy), .is_vec(is_vec), .is_imm(is_imm), .is_pc(is_pc),
        .pc(pc), .imm(imm), .name(name), .rd(rd), .rs1(rs1), .rs2(rs2),
        .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of pending instructions plus the issue slot.
    ent_t m_q[$];
    ent_t m_slot = '0;
    bit   m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_slot  = '0;
            m_valid = 1'b0;
        end else if (rdy) begin
            if (flush) begin
                m_q.delete();
                m_valid = 1'b0;
            end else begin
                automatic int  sz    = m_q.size();
                automatic bit  do_pop  = !issue_stall && sz != 0;
                automatic bit  do_push = in_valid && sz != DEPTH;
                automatic bit  do_byp  = BYP && do_push && sz == 0 && !issue_stall;
                if (do_pop) begin
                    m_slot  = m_q.pop_front();
                    m_valid = 1'b1;
                end else if (do_byp) begin
                    m_slot  = in_e;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
                if (do_push && !do_byp) m_q.push_back(in_e);
            end
        end
    end

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Compare process: every falling edge, away from the active edge.
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            chk("issue_rdy", 96'(issue_rdy), 96'(m_valid));
            chk("count", 96'(count), 96'(m_q.size()));
            chk("in_ready", 96'(in_ready), 96'(m_q.size() != DEPTH));
            chk("payload", 96'({is_vec, is_imm, is_pc, pc, imm, name, rd, rs1, rs2}), 96'(m_slot));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic set_in(input logic v, input logic [31:0] im, input logic [5:0] nm,
                          input logic [31:0] p, input logic [4:0] d);
        in_valid    = v;
        in_e        = '0;
        in_e.imm    = im;
        in_e.name   = nm;
        in_e.pc     = p;
        in_e.rd     = d;
        in_e.rs1    = 5'd1;
        in_e.rs2    = 5'd2;
    endtask

    task automatic drain();
        in_valid = 1'b0; issue_stall = 1'b0; flush = 1'b0; rdy = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cyc();
    endtask

    initial begin
        // Reset then idle.
        #13;
        rst_n = 1'b1;
        check_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i == 9) begin
                chk("idle_issue_rdy", 96'(issue_rdy), 96'd0);
                chk("idle_count", 96'(count), 96'd0);
                chk("idle_in_ready", 96'(in_ready), 96'd1);
                chk("idle_imm", 96'(imm), 96'd0);
                chk("idle_pc", 96'(pc), 96'd0);
            end
        end

        // Single push: ADD rd=3 rs1=1 rs2=2 pc=0x100.
        set_in(1'b1, 32'd7, ADD, 32'h100, 5'd3);
        cyc();
        in_valid = 1'b0;
        chk("single_e0_issue", 96'(issue_rdy), 96'(BYP));
        if (!BYP) cyc();
        chk("single_issue", 96'(issue_rdy), 96'd1);
        chk("single_name", 96'(name), 96'(ADD));
        chk("single_pc", 96'(pc), 96'h100);
        chk("single_rd", 96'(rd), 96'd3);
        cyc();
        chk("single_drop", 96'(issue_rdy), 96'd0);
        chk("single_count", 96'(count), 96'd0);

        // Fill to full with stall; 9th push refused.
        issue_stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, 32'(i), SUB, 32'h200 + 32'(4 * i), 5'd4);
            cyc();
        end
        in_valid = 1'b0;
        chk("full_count", 96'(count), 96'd8);
        chk("full_in_ready", 96'(in_ready), 96'd0);
        issue_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("fill_issue", 96'(issue_rdy), 96'd1);
            chk("fill_order", 96'(imm), 96'(i));
        end
        cyc();
        chk("fill_empty", 96'(count), 96'd0);

        // Second partial fill so head/tail wrap from an offset.
        issue_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'(50 + i), LW, 32'h300, 5'd5);
            cyc();
        end
        in_valid = 1'b0;
        drain();

        // Simultaneous push/pop at count=4.
        issue_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(100 + i), ADD, 32'h400, 5'd6);
            cyc();
        end
        issue_stall = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_in(1'b1, 32'(104 + k), ADD, 32'h400, 5'd6);
            cyc();
            chk("pp_count", 96'(count), 96'd4);
            chk("pp_order", 96'(imm), 96'(100 + k));
        end
        drain();

        // rdy=0 while an issue is held.
        issue_stall = 1'b1;
        set_in(1'b1, 32'h55, ADD, 32'h500, 5'd7); cyc();
        set_in(1'b1, 32'h56, ADD, 32'h504, 5'd7); cyc();
        in_valid = 1'b0;
        issue_stall = 1'b0;
        cyc();
        chk("hold_start", 96'(imm), 96'h55);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_issue", 96'(issue_rdy), 96'd1);
            chk("hold_imm", 96'(imm), 96'h55);
        end
        rdy = 1'b1;
        cyc();
        chk("resume_next", 96'(imm), 96'h56);
        chk("resume_issue", 96'(issue_rdy), 96'd1);
        drain();

        // Flush with a pending push at count=5.
        issue_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'(200 + i), SUB, 32'h600, 5'd8);
            cyc();
        end
        flush = 1'b1;
        set_in(1'b1, 32'hEE, SUB, 32'h700, 5'd9);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        issue_stall = 1'b0;
        chk("flush_count", 96'(count), 96'd0);
        chk("flush_issue", 96'(issue_rdy), 96'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("flush_quiet", 96'(issue_rdy), 96'd0);
        end

        // Randomized traffic, one mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            in_valid    = ($urandom_range(0, 99) < 70);
            issue_stall = ($urandom_range(0, 99) < 30);
            rdy         = ($urandom_range(0, 99) < 85);
            flush       = ($urandom_range(0, 99) < 3);
            in_e        = ent_t'({$urandom, $urandom, $urandom});
            if (n == 1500) rst_n = 1'b0;
            if (n == 1502) rst_n = 1'b1;
            cyc();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

In-order decoded-instruction FIFO between the decoder and the scalar ALU (SALU). Buffers up to `DEPTH` decoded instructions. Presents one instruction per cycle to the ALU through a registered issue slot (`issue_rdy` plus operand-select fields), and supplies `rs1`/`rs2` to the register file for operand read. Supports downstream stall, global pause (`rdy`) and full flush on redirect.

## Interface
Parameters:
- `DEPTH`, 8, number of entries; power of two, ≥ 2
- `ADDR_W`, 3, log2(`DEPTH`)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `rdy`  in  1  global enable; when 0, all state holds
- `flush`  in  1  discard all queued and issuing instructions
- `issue_stall`  in  1  downstream cannot accept a new issue this cycle
- `in_valid`  in  1  decoder offers an instruction
- `in_ready`  out  1  queue can accept (`count != DEPTH`)
- `in_is_vec`, `in_is_imm`, `in_is_pc`  in  1 each  decoded flags
- `in_pc`, `in_imm`  in  32 each  instruction PC, immediate
- `in_name`  in  6  opcode enum (`ADD`, `SUB`, `LW`, …)
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices
- `issue_rdy`  out  1  issue slot holds a valid instruction
- `is_vec`, `is_imm`, `is_pc`, `pc`, `imm`, `name`, `rd`, `rs1`, `rs2`  out  (as input widths)  registered issue-slot payload
- `count`  out  `ADDR_W`+1  current occupancy

## Operation
- **Storage:**
  - Circular buffer of `DEPTH` entries; each entry holds {is_vec, is_imm, is_pc, pc, imm, name, rd, rs1, rs2}.
  - `head`/`tail` pointers are `ADDR_W` bits and wrap naturally from `DEPTH-1` to 0.
- **Push:** `push = rdy & ~flush & in_valid & in_ready`. Entry is written at `tail`, and `tail` increments.
- **Pop:** `pop = rdy & ~flush & ~issue_stall & (count != 0)`.
  - The entry at `head` is loaded into the issue slot, `issue_rdy <= 1`, and `head` increments.
- **No-pop cycle:** when `rdy=1` and no pop occurs, `issue_rdy <= 0`. Payload outputs hold their last values.
- **Count:** `count` changes by +1 on push only, −1 on pop only, and is unchanged on both or neither.
- **Full:** when `in_ready=0` (`count==DEPTH`), pushes are refused even if a pop occurs in the same cycle. There is no pass-through when full.
- **Empty:** pop is impossible; `issue_rdy` falls to 0 on the next `rdy` edge.
- **`rdy=0`:** pointers, count, storage and all outputs (including `issue_rdy`) hold. A held `issue_rdy=1` is consumed by the ALU on the next `rdy=1` edge.
- **Flush** (requires `rdy=1`) has priority over push and pop: `head`, `tail` and `count` reset to 0, and `issue_rdy <= 0`. A push offered in the flush cycle is dropped.
- **Reset** (`rst=0`, asynchronous): pointers, `count`, `issue_rdy` and all payload outputs are 0. Storage contents are don't-care. Reset mid-operation discards everything.

## Timing
- `in_ready` is combinational from `count` only; there is no input-to-output combinational path.
- All issue-slot outputs are registered.
- **Push-to-issue latency:** an instruction pushed at edge E0 into an empty, unstalled queue raises `issue_rdy` after edge E1 (2 edges), without bypass.
- **Throughput:** one push and one pop per cycle sustained.
- `issue_rdy` is high for exactly one `rdy=1` cycle per issued instruction.

## Configuration
- **`IQ_BYPASS_EN` defined:**
  - Condition: `count==0`, push occurs, and `~issue_stall`.
  - The incoming instruction loads the issue slot directly at the same edge, with `issue_rdy <= 1`.
  - It is not written to storage; `count` and pointers are unchanged.
  - Result: push-to-issue latency is 1 edge.
- **`IQ_BYPASS_EN` undefined:** every instruction passes through storage, giving 2-edge latency. Ordering is identical in both builds.

## Test plan
- **Reset then idle:** `rst=0` pulse, `in_valid=0` for 10 cycles → `issue_rdy=0`, `count=0`, all payload outputs 0, `in_ready=1`.
- **Single push, ADD:** `rd=3`, `rs1=1`, `rs2=2`, `pc=0x100` → `issue_rdy=1` for exactly one cycle, 2 edges later (1 with `IQ_BYPASS_EN`), with `name=ADD`, `pc=0x100`, `rd=3`; `count` returns to 0.
- **Fill to full:** `issue_stall=1`, push 9 instructions with `imm=0..8` → `count=8`, `in_ready=0`, 9th not accepted. Then `issue_stall=0` → issues in order `imm=0..7`, one per cycle; `head` wraps correctly on a second fill.
- **Simultaneous push/pop:** at `count=4` with continuous push and pop for 20 cycles → `count` stays 4; issued `imm` sequence is strictly in push order.
- **`rdy=0` mid-issue:** drop `rdy` for 3 cycles while `issue_rdy=1`, `imm=0x55` → `issue_rdy` and `imm` hold at 1/0x55; on resume exactly one issue of 0x55 precedes the next entry.
- **Flush with pending push:** `count=5`, `flush=1` with `in_valid=1` → next cycle `count=0`, `issue_rdy=0`, pushed instruction never issues.
